uart_tx_device: RTL and testbench

UART_TX_DEVICE -- requirements
Module: uart_tx_device

---
 rtl/uart_tx_device_if.sv | 19 +
 rtl/uart_tx_device.sv | 116 +++++++++++
 tb/tb_uart_tx_device.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_device_if.sv
// uart_tx_device_if: single-cycle device bus between the core and the UART transmitter.
interface uart_tx_device_if;
  logic        dev_req_i;
  logic        dev_we_i;
  logic [3:0]  dev_be_i;
  logic [31:0] dev_addr_i;
  logic [31:0] dev_wdata_i;
  logic        dev_rvalid_o;
  logic [31:0] dev_rdata_o;
  logic        dev_err_o;
  modport master (
    output dev_req_i, dev_we_i, dev_be_i, dev_addr_i, dev_wdata_i,
    input  dev_rvalid_o, dev_rdata_o, dev_err_o
  );
  modport slave (
    input  dev_req_i, dev_we_i, dev_be_i, dev_addr_i, dev_wdata_i,
    output dev_rvalid_o, dev_rdata_o, dev_err_o
  );
endinterface

// File: rtl/uart_tx_device.sv
// uart_tx_device: memory-mapped 8N1 UART transmitter with byte FIFO, programmable bit time and TX-done interrupt.
module uart_tx_device #(
  parameter int          FifoDepth   = 8,
  parameter logic [15:0] ClkDivReset = 16'd868
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  uart_tx_device_if.slave dev,
  output logic            uart_tx_o,
  output logic            irq_o
);
  localparam int AW = $clog2(FifoDepth);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  state_e      state_q;
  logic [7:0]  mem_q [FifoDepth];
  logic [AW:0] wptr_q, rptr_q;
  logic [15:0] clkdiv_q, cnt_q, div_m1;
  logic [7:0]  sh_q;
  logic [2:0]  idx_q;
  logic        ovf_q, irq_en_q, tx_q, irq_q, rvalid_q, err_q;
  logic [31:0] rdata_q, rdata_d;
  logic [9:0]  off;
  logic        hit_tx, hit_st, hit_div, hit_ctrl, bad, wr, rd, tx_wr, push, pop, full, empty, busy;
  logic        unused_ok;
  assign off      = dev.dev_addr_i[9:0];
  assign hit_tx   = off == 10'h000;
  assign hit_st   = off == 10'h004;
  assign hit_div  = off == 10'h008;
  assign hit_ctrl = off == 10'h00C;
  assign bad      = ~(hit_tx | hit_st | hit_div | hit_ctrl);
  assign wr       = dev.dev_req_i & dev.dev_we_i & ~bad;
  assign rd       = dev.dev_req_i & ~dev.dev_we_i;
  assign empty    = wptr_q == rptr_q;
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign busy     = state_q != IDLE;
  // Full is taken from the registered pointers, so a same-cycle pop never makes room for a push.
  assign tx_wr    = wr & hit_tx & dev.dev_be_i[0];
  assign push     = tx_wr & ~full;
  assign pop      = ~busy & ~empty;
  assign div_m1   = (clkdiv_q == 16'd0) ? 16'd0 : clkdiv_q - 16'd1;
  assign rdata_d  = !rd      ? 32'd0 :
                    hit_st   ? {28'd0, ovf_q, busy, empty, full} :
                    hit_div  ? {16'd0, clkdiv_q} :
                    hit_ctrl ? {31'd0, irq_en_q} : 32'd0;
  assign unused_ok = ^{dev.dev_addr_i[31:10], dev.dev_wdata_i[31:16], dev.dev_be_i[3:2]};
  always_ff @(posedge clk_i)
    if (push) mem_q[wptr_q[AW-1:0]] <= dev.dev_wdata_i[7:0];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      ovf_q    <= 1'b0;
      clkdiv_q <= ClkDivReset;
      irq_en_q <= 1'b0;
    end else begin
      rvalid_q <= dev.dev_req_i;
      rdata_q  <= rdata_d;
      err_q    <= dev.dev_req_i & bad;
      irq_q    <= irq_en_q & empty & ~busy;
      if (push) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop) rptr_q <= rptr_q + (AW+1)'(1);
      if (tx_wr & full) ovf_q <= 1'b1;
      else if (wr & hit_st & dev.dev_be_i[0] & dev.dev_wdata_i[3]) ovf_q <= 1'b0;
      if (wr & hit_div & dev.dev_be_i[0]) clkdiv_q[7:0] <= dev.dev_wdata_i[7:0];
      if (wr & hit_div & dev.dev_be_i[1]) clkdiv_q[15:8] <= dev.dev_wdata_i[15:8];
      if (wr & hit_ctrl & dev.dev_be_i[0]) irq_en_q <= dev.dev_wdata_i[0];
    end
  // Every bit reloads the counter from CLKDIV, so a new divider only takes effect at a bit boundary.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          state_q <= START;
          sh_q    <= mem_q[rptr_q[AW-1:0]];
          tx_q    <= 1'b0;
          cnt_q   <= div_m1;
        end
        START: if (cnt_q == 16'd0) begin
          state_q <= DATA;
          tx_q    <= sh_q[0];
          sh_q    <= sh_q >> 1;
          idx_q   <= '0;
          cnt_q   <= div_m1;
        end else cnt_q <= cnt_q - 16'd1;
        DATA: if (cnt_q == 16'd0) begin
          cnt_q <= div_m1;
          if (idx_q == 3'd7) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            tx_q  <= sh_q[0];
            sh_q  <= sh_q >> 1;
            idx_q <= idx_q + 3'd1;
          end
        end else cnt_q <= cnt_q - 16'd1;
        STOP: if (cnt_q == 16'd0) state_q <= IDLE;
              else cnt_q <= cnt_q - 16'd1;
        default: state_q <= IDLE;
      endcase
    end
  assign uart_tx_o        = tx_q;
  assign irq_o            = irq_q;
  assign dev.dev_rvalid_o = rvalid_q;
  assign dev.dev_rdata_o  = rdata_q;
  assign dev.dev_err_o    = err_q;
endmodule

// File: tb/tb_uart_tx_device.sv
// tb_uart_tx_device: randomized frame/register scenarios checked against a bit-timing model of the UART line.
module tb_uart_tx_device;
  logic clk = 1'b0;
  logic rst_ni;
  logic uart_tx, irq;
  int   checks = 0;
  int   failures = 0;
  logic tx_s  [0:255];
  logic irq_s [0:255];
  uart_tx_device_if bus();
  uart_tx_device #(.FifoDepth(8), .ClkDivReset(16'd868)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .dev(bus), .uart_tx_o(uart_tx), .irq_o(irq)
  );
  always #5 clk = ~clk;

  // Expected line level k cycles after the start edge: first segment lasts l0 cycles, later ones l.
  function automatic logic exp_tx(input logic [7:0] b, input int k, input int l0, input int l);
    int seg;
    seg = (k < l0) ? 0 : 1 + (k - l0) / l;
    if (seg == 0) return 1'b0;
    if (seg <= 8) return b[seg-1];
    return 1'b1;
  endfunction

  task automatic bus_acc(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic rv, output logic [31:0] rd, output logic er);
    @(negedge clk);
    bus.dev_req_i = 1'b1; bus.dev_we_i = we; bus.dev_addr_i = addr;
    bus.dev_wdata_i = wdata; bus.dev_be_i = be;
    @(negedge clk);
    bus.dev_req_i = 1'b0; bus.dev_we_i = 1'b0;
    rv = bus.dev_rvalid_o; rd = bus.dev_rdata_o; er = bus.dev_err_o;
  endtask

  task automatic reg_wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    logic rv, er;
    logic [31:0] rd;
    bus_acc(1'b1, addr, wdata, be, rv, rd, er);
  endtask

  task automatic reg_rd(input logic [31:0] addr, output logic [31:0] data);
    logic rv, er;
    bus_acc(1'b0, addr, 32'd0, 4'd0, rv, data, er);
  endtask

  task automatic capture(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) ok = 1'b1;
    end
    if (ok) begin
      tx_s[0] = uart_tx; irq_s[0] = irq;
      for (int i = 1; i < n; i++) begin
        @(negedge clk);
        tx_s[i] = uart_tx; irq_s[i] = irq;
      end
    end
  endtask

  task automatic wait_tx_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_ni = 1'b0; bus.dev_req_i = 1'b1; bus.dev_addr_i = 32'h4;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.dev_rvalid_o !== 1'b0 || bus.dev_rdata_o !== 32'd0 || bus.dev_err_o !== 1'b0 || uart_tx !== 1'b1 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: rvalid=%b rdata=%h err=%b tx=%b irq=%b, want 0 0 0 1 0",
               bus.dev_rvalid_o, bus.dev_rdata_o, bus.dev_err_o, uart_tx, irq);
    end
    bus.dev_req_i = 1'b0; rst_ni = 1'b1;
    reg_rd(32'h4, d);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL reset_status: got %h want 00000002", d); end
    reg_rd(32'h8, d);
    checks++; if (d !== 32'd868) begin failures++; $display("FAIL reset_clkdiv: got %0d want 868", d); end
    reg_rd(32'hC, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_ctrl: got %h want 0", d); end
  endtask

  task automatic test_regs();
    logic rv, er;
    logic [31:0] d;
    bus_acc(1'b1, 32'h8, 32'h0000_1234, 4'b0011, rv, d, er);
    checks++;
    if (rv !== 1'b1 || d !== 32'd0 || er !== 1'b0) begin
      failures++; $display("FAIL write_response: rvalid=%b rdata=%h err=%b want 1 0 0", rv, d, er);
    end
    reg_rd(32'h8, d);
    checks++; if (d !== 32'h1234) begin failures++; $display("FAIL clkdiv_full: got %h want 1234", d); end
    reg_wr(32'h8, 32'h0000_ABCD, 4'b0001);
    reg_rd(32'h8, d);
    checks++; if (d !== 32'h12CD) begin failures++; $display("FAIL clkdiv_lane0: got %h want 12CD", d); end
    reg_wr(32'h8, 32'h0000_5600, 4'b0010);
    reg_rd(32'h1000_0008, d);
    checks++; if (d !== 32'h56CD) begin failures++; $display("FAIL clkdiv_lane1_alias: got %h want 56CD", d); end
    bus_acc(1'b1, 32'h0, 32'h55, 4'b1110, rv, d, er);
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL txdata_be0_clear_err: got %b want 0", er); end
    reg_rd(32'h4, d);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL txdata_be0_clear_ignored: status %h want 2", d); end
    bus_acc(1'b0, 32'h0, 32'd0, 4'd0, rv, d, er);
    checks++;
    if (rv !== 1'b1 || d !== 32'd0 || er !== 1'b0) begin
      failures++; $display("FAIL txdata_read: rvalid=%b rdata=%h err=%b want 1 0 0", rv, d, er);
    end
    reg_wr(32'hC, 32'h1, 4'b0001);
    reg_rd(32'hC, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL ctrl_rw: got %h want 1", d); end
    repeat (2) @(negedge clk);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_idle_enabled: got %b want 1", irq); end
    reg_wr(32'hC, 32'h0, 4'b0001);
    repeat (2) @(negedge clk);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_disabled: got %b want 0", irq); end
  endtask

  task automatic test_error();
    logic rv, er;
    logic [31:0] d;
    bus_acc(1'b0, 32'h10, 32'd0, 4'd0, rv, d, er);
    checks++;
    if (rv !== 1'b1 || er !== 1'b1 || d !== 32'd0) begin
      failures++; $display("FAIL bad_read: rvalid=%b err=%b rdata=%h want 1 1 0", rv, er, d);
    end
    @(negedge clk);
    checks++;
    if (bus.dev_rvalid_o !== 1'b0 || bus.dev_err_o !== 1'b0 || bus.dev_rdata_o !== 32'd0) begin
      failures++; $display("FAIL idle_response: rvalid=%b err=%b rdata=%h want 0 0 0",
                           bus.dev_rvalid_o, bus.dev_err_o, bus.dev_rdata_o);
    end
    bus_acc(1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, rv, d, er);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL bad_write_err: got %b want 1", er); end
    reg_rd(32'h8, d);
    checks++; if (d !== 32'h56CD) begin failures++; $display("FAIL bad_access_clkdiv: got %h want 56CD", d); end
    reg_rd(32'h4, d);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL bad_access_status: got %h want 2", d); end
  endtask

  task automatic test_frames();
    int divs[5] = '{4, 0, 1, 3, 2};
    for (int it = 0; it < 5; it++) begin
      logic [7:0] b;
      logic [31:0] st0, st1;
      int eff, n, bad, first;
      bit ok;
      b = (it == 0) ? 8'hA5 : 8'($urandom);
      eff = (divs[it] == 0) ? 1 : divs[it];
      n = 10 * eff + 2;
      reg_wr(32'h8, 32'(divs[it]), 4'b0011);
      fork
        capture(n, ok);
        begin
          reg_wr(32'h0, {24'd0, b}, 4'b0001);
          @(negedge clk);
          reg_rd(32'h4, st0);
          reg_rd(32'h4, st1);
        end
      join
      bad = 0; first = -1;
      for (int k = 0; k < n; k++)
        if (tx_s[k] !== exp_tx(b, k, eff, eff)) begin
          if (bad == 0) first = k;
          bad++;
        end
      checks++;
      if (!ok || bad != 0) begin
        failures++;
        $display("FAIL frame_%0d: byte=%h div=%0d started=%0b bad_samples=%0d first_at=%0d want 0 bad samples",
                 it, b, divs[it], ok, bad, first);
      end
      checks++;
      if (st0[2] !== 1'b1 || st1[2] !== 1'b1) begin
        failures++; $display("FAIL busy_in_frame_%0d: got %b,%b want 1,1", it, st0[2], st1[2]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b0, b1;
    logic e;
    int bad, first, irq_bad;
    bit ok;
    b0 = 8'($urandom); b1 = 8'($urandom);
    reg_wr(32'h8, 32'd2, 4'b0011);
    reg_wr(32'hC, 32'h1, 4'b0001);
    repeat (2) @(negedge clk);
    fork
      capture(45, ok);
      begin
        reg_wr(32'h0, {24'd0, b0}, 4'b0001);
        reg_wr(32'h0, {24'd0, b1}, 4'b0001);
      end
    join
    bad = 0; first = -1; irq_bad = 0;
    for (int k = 0; k < 45; k++) begin
      e = (k < 20) ? exp_tx(b0, k, 2, 2) : (k == 20) ? 1'b1 : exp_tx(b1, k - 21, 2, 2);
      if (tx_s[k] !== e) begin
        if (bad == 0) first = k;
        bad++;
      end
      if (k <= 40 && irq_s[k] !== 1'b0) irq_bad++;
    end
    checks++;
    if (!ok || bad != 0) begin
      failures++;
      $display("FAIL back_to_back_line: bytes=%h,%h started=%0b bad_samples=%0d first_at=%0d want 0",
               b0, b1, ok, bad, first);
    end
    checks++;
    if (irq_bad != 0) begin failures++; $display("FAIL irq_during_frames: high in %0d samples want 0", irq_bad); end
    checks++;
    if (irq_s[43] !== 1'b1) begin failures++; $display("FAIL irq_after_frames: got %b want 1", irq_s[43]); end
    reg_wr(32'hC, 32'h0, 4'b0001);
  endtask

  task automatic test_clkdiv_change();
    logic [7:0] b;
    int bad, first;
    bit ok, ok2;
    b = 8'($urandom);
    reg_wr(32'h8, 32'd4, 4'b0011);
    fork
      capture(78, ok);
      reg_wr(32'h0, {24'd0, b}, 4'b0001);
      begin
        wait_tx_low(ok2);
        if (ok2) reg_wr(32'h8, 32'd8, 4'b0011);
      end
    join
    bad = 0; first = -1;
    for (int k = 0; k < 78; k++)
      if (tx_s[k] !== exp_tx(b, k, 4, 8)) begin
        if (bad == 0) first = k;
        bad++;
      end
    checks++;
    if (!ok || bad != 0) begin
      failures++;
      $display("FAIL clkdiv_change: byte=%h started=%0b bad_samples=%0d first_at=%0d want 0", b, ok, bad, first);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    logic [31:0] d;
    int lows;
    bit ok;
    b = 8'($urandom) & 8'hF7;
    reg_wr(32'h8, 32'd4, 4'b0011);
    reg_wr(32'h0, {24'd0, b}, 4'b0001);
    wait_tx_low(ok);
    repeat (17) @(negedge clk);
    checks++;
    if (!ok || uart_tx !== 1'b0) begin failures++; $display("FAIL midframe_bit3: started=%0b tx=%b want 1,0", ok, uart_tx); end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1 || irq !== 1'b0 || bus.dev_rvalid_o !== 1'b0) begin
      failures++; $display("FAIL async_reset: tx=%b irq=%b rvalid=%b want 1 0 0", uart_tx, irq, bus.dev_rvalid_o);
    end
    @(negedge clk); @(negedge clk);
    #2 rst_ni = 1'b1;
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    checks++; if (lows != 0) begin failures++; $display("FAIL no_partial_frame: low samples %0d want 0", lows); end
    reg_rd(32'h4, d);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL post_reset_status: got %h want 2", d); end
    reg_rd(32'h8, d);
    checks++; if (d !== 32'd868) begin failures++; $display("FAIL post_reset_clkdiv: got %0d want 868", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    reg_wr(32'h8, 32'hFFFF, 4'b0011);
    reg_wr(32'h0, 32'h11, 4'b0001);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) reg_wr(32'h0, 32'($urandom_range(0, 255)), 4'b0001);
    reg_rd(32'h4, d);
    checks++; if ((d & 32'hB) !== 32'h1) begin failures++; $display("FAIL fifo_full_no_ovf: status %h want 1 in bits 3,1,0", d); end
    reg_wr(32'h0, 32'($urandom_range(0, 255)), 4'b0001);
    reg_rd(32'h4, d);
    checks++; if ((d & 32'hB) !== 32'h9) begin failures++; $display("FAIL overflow_status: status %h want 9 in bits 3,1,0", d); end
    checks++; if (d[2] !== 1'b1) begin failures++; $display("FAIL stalled_busy: got %b want 1", d[2]); end
    reg_wr(32'h4, 32'h8, 4'b0001);
    reg_rd(32'h4, d);
    checks++; if ((d & 32'hB) !== 32'h1) begin failures++; $display("FAIL overflow_w1c: status %h want 1 in bits 3,1,0", d); end
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    reg_rd(32'h4, d);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL flush_by_reset: status %h want 2", d); end
  endtask

  initial begin
    rst_ni = 1'b0;
    bus.dev_req_i = 1'b0; bus.dev_we_i = 1'b0; bus.dev_be_i = 4'd0;
    bus.dev_addr_i = 32'd0; bus.dev_wdata_i = 32'd0;
    test_reset();
    test_regs();
    test_error();
    test_frames();
    test_back_to_back();
    test_clkdiv_change();
    test_reset_midframe();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
